data_mem_resp: RTL and testbench

Word-addressed data-memory responder on the load/store side of the single-cycle data path. It accepts one request at a time over a valid/ready request channel and inserts a programmable number of wait states. It commits stores and returns load data over a valid/ready response channel. It is the memory end of the address / write-data / mem-write / read-data interface the core drives.

---
 rtl/data_mem_resp.sv | 123 ++++++++++++
 tb/tb_data_mem_resp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Word-addressed data-memory responder with programmable wait states.
// One request at a time on a valid/ready request channel. Stores are committed and
// load data is returned on a valid/ready response channel.
// Optional build macro: DMEM_ALIGN_CHECK_EN. When it is defined, a misaligned byte
// address (req_addr[1:0] != 0) is flagged as an error.
module data_mem_resp #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2   // legal range 0..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  WaitCnt = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;

  logic [31:0]           mem_q [Depth];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  range_err;
  logic                  align_err;
  logic                  req_err;
  logic                  commit;

  // Decode the latched request: word index and error conditions
  always_comb begin
    word_idx  = addr_q[DEPTH_LOG2+1:2];
    // Any set bit above the word-index field means the address is past the array.
    range_err = |(addr_q >> (DEPTH_LOG2 + 2));
`ifdef DMEM_ALIGN_CHECK_EN
    align_err = |addr_q[1:0];
`else
    align_err = 1'b0;
`endif
    req_err   = range_err | align_err;
  end

  // RESP is entered one edge before the response is presented; the first edge spent in
  // RESP (resp_valid still low) is the single commit/read edge.
  assign commit = (state_q == StResp) && !resp_valid_q;

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (WaitCnt == 4'd0) begin
              state_q <= StResp;
            end else begin
              cnt_q   <= WaitCnt;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= req_err;
            // Stores and errored requests return zero data.
            resp_rdata_q <= (we_q || req_err) ? 32'd0 : mem_q[word_idx];
          end else if (resp_ready) begin
            // rdata/err deliberately keep their value after the handshake.
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory array: written on the commit edge only; never cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && commit && we_q && !req_err) begin
      mem_q[word_idx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  localparam int unsigned WaitCycles = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total;
  int bad;

  // Expected responses: {err, rdata}
  logic [32:0] exp_q[$];

  data_mem_resp #(
    .DEPTH_LOG2  (8),
    .WAIT_CYCLES (WaitCycles)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one pop per completed response handshake
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b expected none",
                 resp_rdata, resp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e[31:0]);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
      end
    end
  end

  // Issue one request; returns once resp_valid is seen (or after a bounded wait).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input bit check_lat);
    int lat;
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: got no resp_valid expected within %0d edges",
               WaitCycles + 1);
    end else if (check_lat) begin
      chk("latency", 32'(lat), 32'(WaitCycles + 1));
    end
  endtask

  // Wait (bounded) for the response to be consumed.
  task automatic drain();
    int guard;
    guard = 0;
    while (resp_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drained", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;

    // 1. Reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);

    // 2. Store then load, resp_ready tied high
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    drain();
    issue(1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
    drain();

    // 3. Load held for 5 cycles with resp_ready low
    issue(1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    drain();
    resp_ready = 1'b0;
    issue(1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'hCAFEF00D);
      chk("hold_err", {31'd0, resp_err}, 32'd0);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {31'd0, resp_valid}, 32'd0);
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("release_rdata_kept", resp_rdata, 32'hCAFEF00D);

    // 4. Out-of-range store does not alias onto word 0
    issue(1'b1, 32'h0, 32'hA5A50000, 32'd0, 1'b0, 1'b0);
    drain();
    issue(1'b1, 32'h400, 32'h12345678, 32'd0, 1'b1, 1'b1);
    drain();
    issue(1'b0, 32'h0, 32'd0, 32'hA5A50000, 1'b0, 1'b0);
    drain();
    issue(1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1, 1'b0);
    drain();

    // 5. Reset during WAIT discards a pending store
    issue(1'b1, 32'h30, 32'h11111111, 32'd0, 1'b0, 1'b0);
    drain();
    while (!req_ready) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("wait_rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("wait_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    issue(1'b0, 32'h30, 32'd0, 32'h11111111, 1'b0, 1'b1);
    drain();

    // 6. Misaligned store
`ifdef DMEM_ALIGN_CHECK_EN
    issue(1'b1, 32'h31, 32'h33333333, 32'd0, 1'b1, 1'b1);
    drain();
    issue(1'b0, 32'h30, 32'd0, 32'h11111111, 1'b0, 1'b0);
    drain();
`else
    issue(1'b1, 32'h31, 32'h33333333, 32'd0, 1'b0, 1'b1);
    drain();
    issue(1'b0, 32'h30, 32'd0, 32'h33333333, 1'b0, 1'b0);
    drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
